// File: rtl/ascon_block_feeder.sv
// Host byte-stream sequencer for ascon_top: packs one padded AD block and N_PT_BLOCKS
// plaintext blocks into 128-bit words and paces them on the core's end_* handshake flags.
module ascon_block_feeder #(
  parameter int N_PT_BLOCKS = 3
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [7:0]   byte_i,
  input  logic         byte_valid_i,
  input  logic         byte_last_i,
  output logic         byte_ready_o,
  input  logic         end_init_i,
  input  logic         end_associated_i,
  input  logic         end_cipher_i,
  input  logic         end_i,
  output logic         start_o,
  output logic [127:0] key_o,
  output logic [127:0] nonce_o,
  output logic [127:0] data_o,
  output logic         data_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o
);

  localparam int              BW       = $clog2(N_PT_BLOCKS) + 1;
  localparam logic [BW-1:0]   LAST_BLK = BW'(N_PT_BLOCKS - 1);

  typedef enum logic [3:0] {
    IDLE, W_INIT, AD_FILL, AD_SEND, W_AD, PT_FILL, PT_SEND, W_CI, W_END, ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    pack_q, blk_d;
  logic [3:0]      cnt_q;
  logic [BW-1:0]   blk_cnt_q;
  logic            guard_q;
  logic [127:0]    key_q, nonce_q, data_q;
  logic            start_q, dv_q, done_q, err_q, busy_q, ready_q;
  logic            accept, fill_st, is_last_blk;

  assign fill_st     = (state_q == AD_FILL) || (state_q == PT_FILL);
  assign accept      = byte_valid_i && ready_q;
  assign is_last_blk = (blk_cnt_q == LAST_BLK);

  // Packed block as it would look with the current byte inserted (plus padding if it ends the segment)
  always_comb begin
    blk_d = pack_q;
    for (int k = 0; k < 16; k++) begin
      if (cnt_q == 4'(k))
        blk_d[8*k +: 8] = byte_i;
      else if (k > 0 && byte_last_i && cnt_q == 4'(k-1))
        blk_d[8*k +: 8] = 8'h01;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERROR: if (start_i) state_d = W_INIT;
      W_INIT:      if (!guard_q && end_init_i) state_d = AD_FILL;
      AD_FILL: begin
        if (accept) begin
          if (cnt_q == 4'd15)   state_d = ERROR;
          else if (byte_last_i) state_d = AD_SEND;
        end
      end
      AD_SEND:     state_d = W_AD;
      W_AD:        if (!guard_q && end_associated_i) state_d = PT_FILL;
      PT_FILL: begin
        if (accept) begin
          if (!is_last_blk) begin
            if (byte_last_i)          state_d = ERROR;
            else if (cnt_q == 4'd15)  state_d = PT_SEND;
          end else begin
            if (cnt_q == 4'd15)       state_d = ERROR;
            else if (byte_last_i)     state_d = PT_SEND;
          end
        end
      end
      PT_SEND:     state_d = is_last_blk ? W_END : W_CI;
      W_CI:        if (!guard_q && end_cipher_i) state_d = PT_FILL;
      W_END:       if (!guard_q && end_i) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= IDLE;
      pack_q    <= '0;
      cnt_q     <= '0;
      blk_cnt_q <= '0;
      guard_q   <= 1'b0;
      key_q     <= '0;
      nonce_q   <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Wait states see a stale end_* level on entry, so their first cycle is masked
      guard_q <= (state_d != state_q);

      start_q <= (state_q inside {IDLE, ERROR}) && start_i;
      if ((state_q inside {IDLE, ERROR}) && start_i) begin
        key_q   <= key_i;
        nonce_q <= nonce_i;
      end

      dv_q <= (state_d == AD_SEND) || (state_d == PT_SEND);
      if (fill_st && (state_d inside {AD_SEND, PT_SEND}))
        data_q <= blk_d;

      done_q  <= (state_q == W_END) && (state_d == IDLE);
      err_q   <= (state_d == ERROR);
      busy_q  <= !(state_d inside {IDLE, ERROR});
      ready_q <= (state_d inside {AD_FILL, PT_FILL});

      if (fill_st && (state_d == state_q)) begin
        if (accept) begin
          pack_q <= blk_d;
          cnt_q  <= cnt_q + 4'd1;
        end
      end else begin
        pack_q <= '0;
        cnt_q  <= '0;
      end

      if (state_q == W_AD && state_d == PT_FILL)
        blk_cnt_q <= '0;
      else if (state_q == W_CI && state_d == PT_FILL)
        blk_cnt_q <= blk_cnt_q + BW'(1);
    end
  end

  assign byte_ready_o = ready_q;
  assign start_o      = start_q;
  assign key_o        = key_q;
  assign nonce_o      = nonce_q;
  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = err_q;

endmodule
